// File: rtl/pio_fifo_bank.sv
// PIO TX/RX FIFO bank: one TX and one RX fall-through FIFO per state machine,
// with per-SM join (double depth, one direction) and FSTAT/FDEBUG status words.

module pio_fifo_lane #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int CNT_W  = $clog2(2*DEPTH)+1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_joinTx,
    input  logic              i_joinRx,
    input  logic              i_txPush,
    input  logic [DATA_W-1:0] i_txData,
    input  logic              i_txPop,
    input  logic              i_rxPush,
    input  logic [DATA_W-1:0] i_rxData,
    input  logic              i_rxPop,
    output logic [DATA_W-1:0] o_txHead,
    output logic              o_txEmpty,
    output logic              o_txFull,
    output logic [CNT_W-1:0]  o_txLevel,
    output logic [DATA_W-1:0] o_rxHead,
    output logic              o_rxEmpty,
    output logic              o_rxFull,
    output logic [CNT_W-1:0]  o_rxLevel,
    output logic              o_txOver,
    output logic              o_txStall,
    output logic              o_rxStall,
    output logic              o_rxUnder
);
    localparam int PW = $clog2(2*DEPTH);
    localparam logic [CNT_W-1:0] CAP1  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CAP2  = CNT_W'(2*DEPTH);
    localparam logic [PW-1:0]    RBASE = PW'(DEPTH);

    logic [DATA_W-1:0] r_mem [2*DEPTH];
    logic [1:0]        r_j;
    logic [1:0]        w_jIn;
    logic              w_jChg;
    logic [PW-1:0]     r_txWr, r_txRd, r_rxWr, r_rxRd;
    logic [CNT_W-1:0]  r_txLvl, r_rxLvl;
    logic [CNT_W-1:0]  w_txCap, w_rxCap;
    logic [PW-1:0]     w_rxBase;
    logic              w_txPushOk, w_txPopOk, w_rxPushOk, w_rxPopOk;

    function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p, input logic [CNT_W-1:0] cap);
        return ({1'b0, p} == cap - 1'b1) ? '0 : p + 1'b1;
    endfunction

    // Both joins set behaves exactly like no join.
    assign w_jIn  = (i_joinTx ^ i_joinRx) ? {i_joinRx, i_joinTx} : 2'b00;
    assign w_jChg = (w_jIn != r_j);

    always_comb begin
        w_txCap  = CAP1;
        w_rxCap  = CAP1;
        w_rxBase = RBASE;
        case (r_j)
            2'b01: begin w_txCap = CAP2; w_rxCap = '0; end
            2'b10: begin w_txCap = '0; w_rxCap = CAP2; w_rxBase = '0; end
            default: ;
        endcase
    end

    assign o_txLevel = r_txLvl;
    assign o_rxLevel = r_rxLvl;
    assign o_txEmpty = (r_txLvl == '0);
    assign o_rxEmpty = (r_rxLvl == '0);
    assign o_txFull  = (r_txLvl == w_txCap);
    assign o_rxFull  = (r_rxLvl == w_rxCap);

    assign w_txPushOk = i_txPush & ~o_txFull  & ~w_jChg;
    assign w_txPopOk  = i_txPop  & ~o_txEmpty & ~w_jChg;
    assign w_rxPushOk = i_rxPush & ~o_rxFull  & ~w_jChg;
    assign w_rxPopOk  = i_rxPop  & ~o_rxEmpty & ~w_jChg;

    assign o_txOver  = i_txPush & o_txFull  & ~w_jChg;
    assign o_txStall = i_txPop  & o_txEmpty & ~w_jChg;
    assign o_rxStall = i_rxPush & o_rxFull  & ~w_jChg;
    assign o_rxUnder = i_rxPop  & o_rxEmpty & ~w_jChg;

    assign o_txHead = o_txEmpty ? '0 : r_mem[r_txRd];
    assign o_rxHead = o_rxEmpty ? '0 : r_mem[w_rxBase + r_rxRd];

    // TX and RX never write the same entry: joined modes give the other side zero capacity.
    always_ff @(posedge clk) begin
        if (w_txPushOk) r_mem[r_txWr] <= i_txData;
        if (w_rxPushOk) r_mem[w_rxBase + r_rxWr] <= i_rxData;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_j     <= 2'b00;
            r_txWr  <= '0;
            r_txRd  <= '0;
            r_txLvl <= '0;
            r_rxWr  <= '0;
            r_rxRd  <= '0;
            r_rxLvl <= '0;
        end else if (w_jChg) begin
            r_j     <= w_jIn;
            r_txWr  <= '0;
            r_txRd  <= '0;
            r_txLvl <= '0;
            r_rxWr  <= '0;
            r_rxRd  <= '0;
            r_rxLvl <= '0;
        end else begin
            if (w_txPushOk) r_txWr <= f_inc(r_txWr, w_txCap);
            if (w_txPopOk)  r_txRd <= f_inc(r_txRd, w_txCap);
            if (w_rxPushOk) r_rxWr <= f_inc(r_rxWr, w_rxCap);
            if (w_rxPopOk)  r_rxRd <= f_inc(r_rxRd, w_rxCap);
            case ({w_txPushOk, w_txPopOk})
                2'b10:   r_txLvl <= r_txLvl + 1'b1;
                2'b01:   r_txLvl <= r_txLvl - 1'b1;
                default: ;
            endcase
            case ({w_rxPushOk, w_rxPopOk})
                2'b10:   r_rxLvl <= r_rxLvl + 1'b1;
                2'b01:   r_rxLvl <= r_rxLvl - 1'b1;
                default: ;
            endcase
        end
    end
endmodule

module pio_fifo_bank #(
    parameter int NUM_SM = 4,
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    localparam int CNT_W = $clog2(2*DEPTH)+1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_busTxWrite,
    input  logic                     in_busRxRead,
    input  logic [1:0]               in_busSel,
    input  logic [DATA_W-1:0]        in_busData,
    output logic [DATA_W-1:0]        out_busRxData,
    input  logic [31:0]              in_fdebugClear,
    input  logic                     in_fdebugClearEn,
    input  logic [NUM_SM-1:0]        in_joinTx,
    input  logic [NUM_SM-1:0]        in_joinRx,
    input  logic [NUM_SM-1:0]        in_smTxAck,
    output logic [NUM_SM*DATA_W-1:0] out_smTxData,
    output logic [NUM_SM-1:0]        out_smTxEmpty,
    input  logic [NUM_SM-1:0]        in_smRxValid,
    input  logic [NUM_SM*DATA_W-1:0] in_smRxData,
    output logic [NUM_SM-1:0]        out_smRxFull,
    output logic [31:0]              out_FSTAT,
    output logic [31:0]              out_FDEBUG,
    output logic [NUM_SM*CNT_W-1:0]  out_txLevel,
    output logic [NUM_SM*CNT_W-1:0]  out_rxLevel
);
    logic [NUM_SM-1:0][DATA_W-1:0] w_txHead, w_rxHead;
    logic [NUM_SM-1:0][CNT_W-1:0]  w_txLvl, w_rxLvl;
    logic [NUM_SM-1:0] w_hit, w_txEmpty, w_txFull, w_rxEmpty, w_rxFull;
    logic [NUM_SM-1:0] w_txOver, w_txStall, w_rxStall, w_rxUnder;
    logic [DATA_W-1:0] w_busRx;
    logic [31:0]       w_fstat, w_dbgSet, r_fdebug;

    for (genvar i = 0; i < NUM_SM; i++) begin : g_lane
        // Select values with no lane behind them match nothing and are ignored.
        assign w_hit[i] = (in_busSel == 2'(i));
        pio_fifo_lane #(.DEPTH(DEPTH), .DATA_W(DATA_W), .CNT_W(CNT_W)) u_lane (
            .clk       (clk),
            .reset     (reset),
            .i_joinTx  (in_joinTx[i]),
            .i_joinRx  (in_joinRx[i]),
            .i_txPush  (in_busTxWrite & w_hit[i]),
            .i_txData  (in_busData),
            .i_txPop   (in_smTxAck[i]),
            .i_rxPush  (in_smRxValid[i]),
            .i_rxData  (in_smRxData[i*DATA_W +: DATA_W]),
            .i_rxPop   (in_busRxRead & w_hit[i]),
            .o_txHead  (w_txHead[i]),
            .o_txEmpty (w_txEmpty[i]),
            .o_txFull  (w_txFull[i]),
            .o_txLevel (w_txLvl[i]),
            .o_rxHead  (w_rxHead[i]),
            .o_rxEmpty (w_rxEmpty[i]),
            .o_rxFull  (w_rxFull[i]),
            .o_rxLevel (w_rxLvl[i]),
            .o_txOver  (w_txOver[i]),
            .o_txStall (w_txStall[i]),
            .o_rxStall (w_rxStall[i]),
            .o_rxUnder (w_rxUnder[i])
        );
    end

    assign out_smTxData  = w_txHead;
    assign out_smTxEmpty = w_txEmpty;
    assign out_smRxFull  = w_rxFull;
    assign out_txLevel   = w_txLvl;
    assign out_rxLevel   = w_rxLvl;
    assign out_busRxData = w_busRx;
    assign out_FSTAT     = w_fstat;
    assign out_FDEBUG    = r_fdebug;

    always_comb begin
        w_busRx  = '0;
        w_fstat  = '0;
        w_dbgSet = '0;
        for (int i = 0; i < NUM_SM; i++) begin
            if (w_hit[i]) w_busRx = w_rxHead[i];
            w_fstat[i]     = w_rxFull[i];
            w_fstat[8+i]   = w_rxEmpty[i];
            w_fstat[16+i]  = w_txFull[i];
            w_fstat[24+i]  = w_txEmpty[i];
            w_dbgSet[i]    = w_rxStall[i];
            w_dbgSet[8+i]  = w_rxUnder[i];
            w_dbgSet[16+i] = w_txOver[i];
            w_dbgSet[24+i] = w_txStall[i];
        end
    end

    // New events win over a coincident clear of the same bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_fdebug <= '0;
        else        r_fdebug <= (r_fdebug & ~(in_fdebugClearEn ? in_fdebugClear : 32'h0)) | w_dbgSet;
    end
endmodule

// File: doc/pio_fifo_bank.md
# pio_fifo_bank

Parametrised TX/RX FIFO bank for the PIO block: one TX FIFO (bus → state machine) and one RX FIFO (state machine → bus) per state machine. It replaces the constant TX test value and the hard-tied TX-empty / RX-full inputs of the state machines, and supports per-SM FIFO join (double depth, one direction). It also provides RP2040-layout FSTAT and FDEBUG status words for the bus register decoder. It sits between the PIO bus interface and the stateMachine instances.

## Interface
- NUM_SM, 4, number of state machines / FIFO pairs; legal 1..4
- DEPTH, 4, entries per unjoined FIFO; power of 2, 2..8
- DATA_W, 32, FIFO word width
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-low
- in_busTxWrite  in  1  push in_busData into TX FIFO of in_busSel
- in_busRxRead  in  1  pop RX FIFO of in_busSel
- in_busSel  in  2  target SM index; values ≥ NUM_SM are ignored (no effect, no flags)
- in_busData  in  DATA_W  TX push data
- out_busRxData  out  DATA_W  head of RX FIFO of in_busSel; 0 if empty or sel invalid
- in_fdebugClear  in  32  write-1-to-clear mask for FDEBUG, applied when in_fdebugClearEn=1
- in_fdebugClearEn  in  1  FDEBUG clear strobe
- in_joinTx, in_joinRx  in  NUM_SM  per-SM FJOIN_TX / FJOIN_RX (SHIFTCTRL[30] / [31])
- in_smTxAck  in  NUM_SM  SM pops its TX head
- out_smTxData  out  NUM_SM*DATA_W  TX head per SM (SM i at [i*DATA_W +: DATA_W]); 0 when empty
- out_smTxEmpty  out  NUM_SM  TX FIFO empty
- in_smRxValid  in  NUM_SM  SM pushes in_smRxData slice
- in_smRxData  in  NUM_SM*DATA_W  RX push data
- out_smRxFull  out  NUM_SM  RX FIFO full
- out_FSTAT  out  32  RXFULL[3:0], RXEMPTY[11:8], TXFULL[19:16], TXEMPTY[27:24]; other bits 0
- out_FDEBUG  out  32  sticky: RXSTALL[3:0], RXUNDER[11:8], TXOVER[19:16], TXSTALL[27:24]
- out_txLevel, out_rxLevel  out  NUM_SM*CNT_W  occupancy per SM, CNT_W = $clog2(2*DEPTH)+1

## Operation
- Per SM: storage of 2*DEPTH words, TX/RX read and write pointers, TX/RX counters.
- Effective join mode per SM: J = {joinRx, joinTx}. The value 11 is treated as 00.
  - 00: TX and RX capacity each DEPTH.
  - 01 (joinTx): TX capacity 2*DEPTH; RX capacity 0.
  - 10 (joinRx): RX capacity 2*DEPTH; TX capacity 0.
- A zero-capacity FIFO reports both empty=1 and full=1, and has level 0.
- Full = level == capacity; empty = level == 0. Pointers wrap modulo capacity.
- Push on full is dropped, data is discarded, and a flag is set: TX push by bus → TXOVER[i]; RX push by SM → RXSTALL[i].
- Pop on empty: no pointer change, data 0, flag set: RX pop by bus → RXUNDER[i]; TX pop by SM → TXSTALL[i].
- Full/empty for a given cycle are evaluated on pre-edge state. A push on full is dropped even if a pop happens in the same cycle. Push and pop on a non-full, non-empty FIFO in the same cycle leave the level unchanged.
- Bus and SM access different FIFOs, so there are no port conflicts.
- Join change: a registered copy of the effective J is held per SM. When the input J differs from it:
  - that SM's TX and RX pointers and levels are cleared at the next edge;
  - the copy is updated;
  - any push or pop to that SM in the same cycle is discarded, with no flags set.
- FDEBUG bits are set by events and cleared by in_fdebugClearEn & mask. When set and clear coincide on the same bit, set wins.
- FSTAT and levels are pure functions of registered state.

## Timing
- Reset: all pointers and levels 0, J copies 0, FDEBUG = 0.
  - Outputs after reset: out_smTxEmpty = all 1, out_smRxFull = 0, out_smTxData = 0, out_busRxData = 0.
  - FSTAT = 0x0F000F00 for NUM_SM=4 (unused SM bits 0).
- Fall-through FIFO: data pushed at edge N is at the head, and the flags/levels reflect it, from edge N until the next edge. Push-to-head latency is 1 cycle.
- Pop consumes at the edge. The next head is visible the same cycle after that edge.
- Reset asserted mid-operation clears all state asynchronously. Contents are lost.

## Test plan
- Reset → FSTAT=0x0F000F00, FDEBUG=0, all levels 0, out_smTxEmpty=4'hF.
- Bus pushes 0xA0..0xA4 to SM1 TX (DEPTH=4) → level climbs to 4, TXFULL[17]=1. The 5th push is dropped and FDEBUG[17]=1. SM1 acks 4 times → reads 0xA0..0xA3 in order, TXEMPTY[25]=1.
- SM2 pushes 0x11 and 0x22; bus reads SM2 three times → returns 0x11, 0x22, 0. RXUNDER bit 10 set. in_fdebugClear=0x400 with strobe → FDEBUG=0.
- Set joinTx[0] with 2 words pending in SM0 TX → both FIFOs flushed next cycle. TX then accepts 8 pushes; the 9th sets TXOVER[16]. SM0 RX reports full=1 and empty=1; an SM push sets RXSTALL[0].
- Simultaneous bus TX push and SM0 pop at level 2 → level stays 2 and order is preserved. With level 4 (full), push+pop → level 3, push dropped, TXOVER set.
- Set joinTx and joinRx together → behaves as unjoined (DEPTH each). Assert reset mid-burst → all outputs return to their reset values immediately.
